// File: rtl/uart_rx_fifo_if.sv
// Consumer-side byte stream of the UART receive FIFO.
// The FIFO (master) presents out_data with out_valid; the consumer (slave)
// answers with out_ready. A byte moves on a rising clk edge where both
// out_valid and out_ready are 1; out_ready while out_valid=0 has no effect,
// and out_data holds steady until the byte it shows is taken.
interface uart_rx_fifo_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: captures single-cycle
// receiver strobes into a first-word-fall-through FIFO, masks unused upper
// bits for short character formats, and reports level/almost-full/overflow.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int AFULL_LEVEL = DEPTH - 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [2:0]            bit_count_sel,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  clear_overflow,
    uart_rx_fifo_if.master        out_bus,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_L = (ADDR_WIDTH + 1)'(AFULL_LEVEL);

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow_q;

    logic                  push_req;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;
    logic [7:0]            mask;

    assign push_req = enable & in_valid;
    assign pop      = out_bus.out_valid & out_bus.out_ready;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // Character-size mask: keep bits [bit_count_sel+3:0], 8 bits for sel >= 4.
    always_comb begin
        mask = 8'hFF;
        case (bit_count_sel)
            3'd0:    mask = 8'h0F;
            3'd1:    mask = 8'h1F;
            3'd2:    mask = 8'h3F;
            3'd3:    mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= in_data & mask;
        end
    end

    // Pointers, entry count and sticky overflow; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new drop wins over a coincident clear.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Status flags and FWFT head presentation, all combinational from state.
    always_comb begin
        level             = count;
        empty             = (count == '0);
        full              = (count == DEPTH_L);
        almost_full       = (count >= AFULL_L);
        overflow          = overflow_q;
        out_bus.out_valid = (count != '0);
        out_bus.out_data  = (count != '0) ? mem[rd_ptr] : 8'h00;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset state, masking, fill/overflow,
// full push+pop, overflow clear priority, enable gating, reset and wrap.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [2:0] bit_count_sel;
    logic       in_valid;
    logic [7:0] in_data;
    logic       clear_overflow;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .bit_count_sel  (bit_count_sel),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .clear_overflow (clear_overflow),
        .out_bus        (bus.master),
        .level          (level),
        .empty          (empty),
        .full           (full),
        .almost_full    (almost_full),
        .overflow       (overflow)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] sel);
        in_valid      = 1'b1;
        in_data       = d;
        bit_count_sel = sel;
        tick();
        in_valid      = 1'b0;
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        enable         = 1'b1;
        bit_count_sel  = 3'd4;
        in_valid       = 1'b0;
        in_data        = 8'h00;
        clear_overflow = 1'b0;
        bus.out_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 8'h00);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_ovf", overflow, 0);

        // Single byte in/out
        push(8'hA5, 3'd4);
        check("p1_valid", bus.out_valid, 1);
        check("p1_data", bus.out_data, 8'hA5);
        check("p1_level", level, 1);
        pop_one();
        check("p1_pop_valid", bus.out_valid, 0);
        check("p1_pop_data", bus.out_data, 8'h00);
        check("p1_pop_empty", empty, 1);

        // Masking for 7- and 5-bit characters
        push(8'hFF, 3'd3);
        push(8'hFF, 3'd1);
        check("mask_level", level, 2);
        check("mask7", bus.out_data, 8'h7F);
        pop_one();
        check("mask5", bus.out_data, 8'h1F);
        pop_one();
        check("mask_empty", empty, 1);

        // Fill to full
        for (int i = 0; i < 16; i++) begin
            push(8'(i), 3'd4);
            check("fill_level", level, i + 1);
            check("fill_afull", almost_full, (i + 1 >= 12) ? 1 : 0);
            check("fill_full", full, (i + 1 == 16) ? 1 : 0);
        end
        check("fill_ovf", overflow, 0);

        // Overflow drop
        push(8'h55, 3'd4);
        check("ovf_set", overflow, 1);
        check("ovf_level", level, 16);
        check("ovf_head", bus.out_data, 8'h00);

        // Drain in order, dropped byte absent
        for (int i = 0; i < 16; i++) begin
            check("drain_data", bus.out_data, i);
            pop_one();
        end
        check("drain_empty", empty, 1);
        check("drain_ovf_sticky", overflow, 1);

        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("ovf_clear1", overflow, 0);

        // Refill and push+pop while full
        for (int i = 0; i < 16; i++) begin
            push(8'(16 + i), 3'd4);
        end
        check("refill_full", full, 1);
        bus.out_ready = 1'b1;
        push(8'h77, 3'd4);
        bus.out_ready = 1'b0;
        check("fpp_ovf", overflow, 0);
        check("fpp_level", level, 16);
        check("fpp_head", bus.out_data, 8'h11);

        // Clear coincident with a new drop: set wins
        clear_overflow = 1'b1;
        push(8'h88, 3'd4);
        clear_overflow = 1'b0;
        check("clr_vs_set", overflow, 1);
        check("clr_vs_set_level", level, 16);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("clr_alone", overflow, 0);

        for (int i = 0; i < 15; i++) begin
            check("fpp_drain", bus.out_data, 17 + i);
            pop_one();
        end
        check("fpp_last", bus.out_data, 8'h77);
        pop_one();
        check("fpp_empty", empty, 1);

        // enable=0 discards strobes
        push(8'h21, 3'd4);
        push(8'h22, 3'd4);
        enable = 1'b0;
        push(8'h31, 3'd4);
        push(8'h32, 3'd4);
        push(8'h33, 3'd4);
        check("en0_level", level, 2);
        check("en0_ovf", overflow, 0);
        check("en0_head", bus.out_data, 8'h21);
        enable = 1'b1;
        push(8'h23, 3'd4);
        push(8'h24, 3'd4);
        push(8'h25, 3'd4);
        check("pre_rst_level", level, 5);

        // Reset with a byte in flight
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst2_level", level, 0);
        check("rst2_empty", empty, 1);
        check("rst2_valid", bus.out_valid, 0);
        check("rst2_ovf", overflow, 0);
        tick();
        check("rst2_level_hold", level, 0);

        // Pointer wrap with push/pop pairs
        for (int k = 0; k < 40; k++) begin
            push(8'(k) ^ 8'hA0, 3'd4);
            check("wrap_data", bus.out_data, 8'(k) ^ 8'hA0);
            check("wrap_level", level, 1);
            pop_one();
            check("wrap_empty", empty, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART receiver.
- Captures each single-cycle data_valid/rx_data strobe from the receiver into a synchronous first-word-fall-through FIFO.
- Masks unused upper bits for 5–7-bit character formats.
- Presents bytes to the host/bus side over a valid/ready handshake, with level, almost-full and sticky overflow status.

Parameters:
- DEPTH, 16: number of byte entries; power of two, minimum 2.
- ADDR_WIDTH, $clog2(DEPTH): pointer width (derived; do not override).
- AFULL_LEVEL, DEPTH-4: almost_full asserts when level >= AFULL_LEVEL; legal range 1..DEPTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  1 = accept incoming bytes; 0 = incoming strobes ignored.
- bit_count_sel  input  3  character-size select, same encoding the receiver uses; kept bits = [bit_count_sel+3:0]; values >= 4 keep all 8 bits.
- in_valid  input  1  single-cycle byte strobe from receiver (data_valid).
- in_data  input  8  received byte (rx_data), sampled when in_valid=1.
- clear_overflow  input  1  single-cycle clear of the overflow flag.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry when out_valid=1.
- out_data  output  8  head entry; forced to 8'h00 while out_valid=0.
- level  output  ADDR_WIDTH+1  current entry count, 0..DEPTH.
- empty  output  1  level==0.
- full  output  1  level==DEPTH.
- almost_full  output  1  level >= AFULL_LEVEL.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at clk edge): wr/rd pointers=0, level=0, overflow=0. Outputs: out_valid=0, out_data=8'h00, empty=1, full=0, almost_full=0 (level 0 < AFULL_LEVEL).
  - Memory contents are not reset.
  - rst overrides every other input in the same cycle; a byte in flight is lost and no overflow is recorded.
- Push request: push_req = enable & in_valid.
- Pop: pop = out_valid & out_ready. out_ready while out_valid=0 has no effect.
- Push accepted when push_req & (!full | pop).
  - Write in_data & mask to mem[wr_ptr]; wr_ptr increments.
  - Mask: bits above index bit_count_sel+3 are zeroed, using bit_count_sel sampled on the push cycle.
- Pop: rd_ptr increments; the head entry is consumed at that edge.
- Pointers wrap modulo DEPTH (natural binary wrap; DEPTH is a power of two).
- Level update, all registered:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
- Status flags are combinational from level.
- Latency: a byte pushed at edge N appears on out_data with out_valid=1 after edge N (visible in cycle N+1); no extra read latency (FWFT).
- out_data = mem[rd_ptr] while out_valid=1. It must hold stable until popped, independent of concurrent pushes.
- Full plus simultaneous push and pop: both proceed; level stays DEPTH; no overflow.
- Full with push_req and no pop: byte dropped; overflow set at that edge; FIFO contents and level unchanged.
- Overflow flag:
  - Held until clear_overflow=1 or rst.
  - If clear_overflow and a new overflow event occur in the same cycle, overflow remains 1 (set wins).
- enable=0:
  - Strobes are discarded silently; no overflow.
  - Pops and status continue normally; stored data is retained.
- Empty with push_req: push accepted; no pop is possible that cycle because out_valid=0.

Test Plan:
- Reset then push 0xA5 with bit_count_sel=4 → next cycle out_valid=1, out_data=0xA5, level=1; pop with out_ready=1 → out_valid=0, out_data=0x00, empty=1.
- Push 0xFF with bit_count_sel=3, then 0xFF with bit_count_sel=1 → popped values 0x7F then 0x1F, in push order.
- Push 16 bytes 0x00..0x0F with out_ready=0 → almost_full=1 from level 12, full=1 at level 16.
  - Extra push 0x55 → overflow=1, level=16.
  - Drain → 0x00..0x0F in order, 0x55 absent.
- Full FIFO, push 0x77 and pop in the same cycle → no overflow, level=16, 0x77 emerges last.
  - Then clear_overflow coincident with a fresh dropped push → overflow stays 1; lone clear_overflow → overflow=0.
- enable=0 with 3 strobes → level unchanged, overflow=0.
  - rst asserted with level=5 → next cycle level=0, empty=1, out_valid=0, overflow=0; pointer wrap exercised by 40 push/pop pairs with data matching.
